io_input_responder: RTL and testbench
=====================================

Name: io_input_responder

Overview:
Responder side of the CPU's blocking-input (IN) handshake. When the core requests input and stalls, this block collects up to 3 decimal digits from the 4-bit board switches. Each digit is confirmed with a digit button, and the entry is committed with an enter button. The block returns the binary value with a one-cycle valid pulse and drives the three BCD digits for the seven-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable clk cycles required before a debounced button level changes
DATA_W, 32, width of returned data word
MAX_DIGITS, 3, digits retained (fixed at 3; oldest is dropped beyond this)

Ports:
clk  input  1  system clock (divided CPU clock)
reset  input  1  asynchronous, active-high
rd_req  input  1  one-cycle request strobe from control unit on an IN instruction
sw_in  input  4  raw board switches, BCD digit candidate
btn_digit  input  1  raw async push button, confirm digit
btn_enter  input  1  raw async push button, commit entry
busy  output  1  high while an entry is in progress; CPU holds pc
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_data  output  DATA_W  committed value, held until the next commit
disp_uni  output  4  units digit
disp_dez  output  4  tens digit
disp_cent  output  4  hundreds digit
digit_err  output  1  one-cycle pulse when a digit press sees sw_in > 9

Behaviour:
- Reset (async): state IDLE; busy=0, rd_valid=0, rd_data=0, all disp_*=0, digit_err=0, digit count=0, debouncers cleared to released.
- Button path, per button:
  - 2-flop synchronizer.
  - Debouncer: level toggles only after DEBOUNCE_CYCLES consecutive cycles with the synced input differing from the current level; any bounce restarts the count.
  - Rising-edge detector produces a one-cycle press pulse, registered.
  - Press pulse latency from a clean raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- sw_in is sampled through a 2-flop synchronizer, sampled in the same cycle as the digit press pulse.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: busy=0. rd_req=1 -> COLLECT next edge; digits and count cleared, busy=1. Press pulses are ignored in IDLE.
  - COLLECT: busy=1.
    - Digit press with sw<=9: cent<=dez, dez<=uni, uni<=sw, count=min(count+1,3).
    - Digit press with sw>9: no shift; digit_err=1 for that cycle.
    - Enter press -> DONE.
    - rd_req while in COLLECT is ignored (no restart).
  - DONE: rd_data <= cent*100 + dez*10 + uni, zero-extended to DATA_W (max 999); rd_valid=1 for exactly this cycle; busy=0 this cycle; -> IDLE.
- Simultaneous digit and enter press in the same cycle: the digit shift is applied first, and the committed value includes the new digit.
- Enter with zero digits commits 0.
- rd_req in the DONE cycle is ignored. Requester must re-issue after rd_valid.
- disp_* follow the digit registers continuously. They keep the last entry after commit until the next rd_req clears them.
- Multiply-by-constant uses shift-add ({x,6'b0}+{x,5'b0}+{x,2'b0}, {x,3'b0}+{x,1'b0}); no hardware multiplier inferred.
- Reset mid-COLLECT: entry discarded, no rd_valid pulse, outputs return to reset values.

Decomposition:
- Package io_input_pkg:
  - State encoding constants S_IDLE=2'd0, S_COLLECT=2'd1, S_DONE=2'd2.
  - BCD_MAX=4'd9.
  - Default DEBOUNCE_CYCLES.
- Sub-module io_debounce (synchronizer + debounce counter + edge pulse), instantiated once per button. Counter width is clog2(DEBOUNCE_CYCLES+1).

Test Plan:
- Reset mid-entry: rd_req, digits 1 and 2, assert reset -> busy=0, disp_*=0, no rd_valid pulse; a new rd_req starts a clean entry.
- Basic entry (DEBOUNCE_CYCLES=4): rd_req, digits 4,2,7, enter -> rd_valid once, rd_data=427, disp_cent/dez/uni=4/2/7, busy high from cycle after rd_req until the DONE cycle.
- Overflow drop and invalid digit: digits 1,2,3,5 then enter -> rd_data=235. A digit press with sw_in=4'hC -> digit_err pulse, digits unchanged.
- Bounce rejection: raw btn_digit toggled every 2 cycles for 20 cycles, then held high -> exactly one shift, occurring 2+4+1 cycles after the final stable edge.
- Simultaneous press and empty entry: digit (sw=9) and enter pulses in the same cycle with 0 prior digits -> rd_data=9. A separate entry with enter only -> rd_data=0.
- Request handling: rd_req while in COLLECT is ignored (entry continues); presses in IDLE are ignored; rd_data holds 427 across an idle period of 100 cycles.

Source files
------------

// File: rtl/io_input_pkg.sv
// rtl/io_input_pkg.sv - shared types, constants and BCD helper for the IN responder
//
// Purpose: state encoding, BCD limit, default debounce length and the
//          three-digit BCD to binary conversion used at commit time.
// Ports:   none (package).

package io_input_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX          = 4'd9;
    localparam int         DEBOUNCE_DEFAULT = 16;

    // cent*100 + dez*10 + uni built from shifted copies so no multiplier is
    // inferred: 100 = 64+32+4, 10 = 8+2. Max 999 fits in 10 bits.
    function automatic logic [9:0] bcd3_to_bin(input logic [3:0] cent,
                                               input logic [3:0] dez,
                                               input logic [3:0] uni);
        logic [9:0] hundreds;
        logic [9:0] tens;
        hundreds = {cent, 6'b0} + {1'b0, cent, 5'b0} + {4'b0, cent, 2'b0};
        tens     = {3'b0, dez, 3'b0} + {5'b0, dez, 1'b0};
        return hundreds + tens + {6'b0, uni};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - button synchronizer, debouncer and registered press pulse
//
// Purpose: turns a raw asynchronous push button into a clean one-cycle press
//          pulse. Latency from a clean raw rising edge to press_o is
//          2 (sync) + DEBOUNCE_CYCLES (stability) + 1 (edge register) cycles.
// Ports:
//   clk     - system clock
//   reset   - asynchronous, active-high; debounced level returns to released
//   btn_i   - raw button level
//   press_o - one-cycle pulse on each debounced rising edge

module io_debounce
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;

            // Count consecutive cycles the synced input disagrees with the
            // debounced level; any agreeing cycle (a bounce) restarts it.
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end

            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/io_input_responder.sv
// rtl/io_input_responder.sv - responder for the CPU blocking IN handshake
//
// Purpose: on rd_req, stall the core (busy) and collect up to three decimal
//          digits from the switches, each confirmed by the digit button; the
//          enter button commits the binary value with a one-cycle rd_valid.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   rd_req                - one-cycle IN request strobe
//   sw_in[3:0]            - raw switches, BCD candidate digit
//   btn_digit, btn_enter  - raw push buttons
//   busy                  - entry in progress, core holds pc
//   rd_valid, rd_data     - commit pulse and committed value (held)
//   disp_cent/dez/uni     - current BCD digits for the 7-segment decoders
//   digit_err             - one-cycle pulse when a digit press sees sw_in > 9

module io_input_responder
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DATA_W          = 32,
    parameter int MAX_DIGITS      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [3:0]        sw_in,
    input  logic              btn_digit,
    input  logic              btn_enter,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        disp_uni,
    output logic [3:0]        disp_dez,
    output logic [3:0]        disp_cent,
    output logic              digit_err
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_DIGITS);

    logic              digit_press;
    logic              enter_press;
    logic [3:0]        sw_sync1_q;
    logic [3:0]        sw_sync2_q;

    state_e            state_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic              digit_err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [3:0]        uni_q;
    logic [3:0]        dez_q;
    logic [3:0]        cent_q;
    logic [1:0]        digit_cnt_q;

    logic              digit_ok;
    logic [3:0]        uni_d;
    logic [3:0]        dez_d;
    logic [3:0]        cent_d;
    logic [9:0]        commit_value;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_digit),
        .press_o (digit_press)
    );

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_enter),
        .press_o (enter_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= sw_in;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Shifted digits are computed ahead of the FSM so that a digit press in
    // the same cycle as enter is already part of the committed value.
    always_comb begin
        digit_ok = digit_press && (sw_sync2_q <= BCD_MAX);
        uni_d    = uni_q;
        dez_d    = dez_q;
        cent_d   = cent_q;
        if (digit_ok) begin
            cent_d = dez_q;
            dez_d  = uni_q;
            uni_d  = sw_sync2_q;
        end
        commit_value = bcd3_to_bin(cent_d, dez_d, uni_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            digit_err_q <= 1'b0;
            rd_data_q   <= '0;
            uni_q       <= '0;
            dez_q       <= '0;
            cent_q      <= '0;
            digit_cnt_q <= '0;
        end else begin
            rd_valid_q  <= 1'b0;
            digit_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        state_q     <= S_COLLECT;
                        busy_q      <= 1'b1;
                        uni_q       <= '0;
                        dez_q       <= '0;
                        cent_q      <= '0;
                        digit_cnt_q <= '0;
                    end
                end
                S_COLLECT: begin
                    uni_q  <= uni_d;
                    dez_q  <= dez_d;
                    cent_q <= cent_d;
                    if (digit_ok && digit_cnt_q != CNT_MAX) begin
                        digit_cnt_q <= digit_cnt_q + 2'd1;
                    end
                    if (digit_press && !digit_ok) begin
                        digit_err_q <= 1'b1;
                    end
                    // Entering DONE: result and valid are registered here so
                    // they are presented during the DONE cycle itself.
                    if (enter_press) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= DATA_W'(commit_value);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign digit_err = digit_err_q;
    assign disp_uni  = uni_q;
    assign disp_dez  = dez_q;
    assign disp_cent = cent_q;

endmodule

// File: tb/tb_io_input_responder.sv
// tb/tb_io_input_responder.sv - self-checking bench for io_input_responder

module tb_io_input_responder;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          rd_req    = 1'b0;
    logic [3:0]    sw_in     = 4'd0;
    logic          btn_digit = 1'b0;
    logic          btn_enter = 1'b0;
    logic          busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [3:0]    disp_uni;
    logic [3:0]    disp_dez;
    logic [3:0]    disp_cent;
    logic          digit_err;

    int total = 0;
    int bad   = 0;

    io_input_responder #(
        .DEBOUNCE_CYCLES (N),
        .DATA_W          (DW),
        .MAX_DIGITS      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .sw_in     (sw_in),
        .btn_digit (btn_digit),
        .btn_enter (btn_enter),
        .busy      (busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .disp_uni  (disp_uni),
        .disp_dez  (disp_dez),
        .disp_cent (disp_cent),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A press takes effect 4 edges after the edge at which the raw button has
    // been seen different from its debounced level for N samples in a row
    // (2 sync edges + the registered pulse + the FSM edge).
    typedef enum int {M_IDLE, M_COLLECT, M_DONE} mphase_e;

    mphase_e    m_phase = M_IDLE;
    int         m_digits[$];
    int         m_data  = 0;
    bit         m_valid = 0;
    bit         m_err   = 0;
    int         run_d = 0, run_e = 0;
    bit         lvl_d = 0, lvl_e = 0;
    bit         pend_d[8];
    bit         pend_e[8];
    logic [3:0] sw_hist[8];
    int         cyc = 0;
    bit         dp, ep;
    int         sw_used;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_digits.delete();
            m_data  = 0;
            m_valid = 0;
            m_err   = 0;
            run_d = 0; run_e = 0; lvl_d = 0; lvl_e = 0;
            for (int i = 0; i < 8; i++) begin
                pend_d[i] = 0; pend_e[i] = 0; sw_hist[i] = 4'd0;
            end
            cyc = 0;
        end else begin
            dp = pend_d[cyc & 7];
            ep = pend_e[cyc & 7];
            pend_d[cyc & 7] = 0;
            pend_e[cyc & 7] = 0;
            sw_used = int'(sw_hist[(cyc + 6) & 7]);

            if (btn_digit != lvl_d) begin
                run_d++;
                if (run_d == N) begin
                    lvl_d = btn_digit; run_d = 0;
                    if (lvl_d) pend_d[(cyc + 4) & 7] = 1;
                end
            end else run_d = 0;
            if (btn_enter != lvl_e) begin
                run_e++;
                if (run_e == N) begin
                    lvl_e = btn_enter; run_e = 0;
                    if (lvl_e) pend_e[(cyc + 4) & 7] = 1;
                end
            end else run_e = 0;

            m_valid = 0;
            m_err   = 0;
            case (m_phase)
                M_IDLE: if (rd_req) begin
                    m_phase = M_COLLECT;
                    m_digits.delete();
                end
                M_COLLECT: begin
                    if (dp) begin
                        if (sw_used <= 9) begin
                            m_digits.push_back(sw_used);
                            if (m_digits.size() > 3) void'(m_digits.pop_front());
                        end else m_err = 1;
                    end
                    if (ep) begin
                        m_data = 0;
                        foreach (m_digits[i]) m_data = m_data * 10 + m_digits[i];
                        m_valid = 1;
                        m_phase = M_DONE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase

            sw_hist[cyc & 7] = sw_in;
            cyc++;
        end
    end

    function automatic int nth_from_end(int k);
        int s;
        s = m_digits.size();
        return (s > k) ? m_digits[s - 1 - k] : 0;
    endfunction

    // ---------------- per-cycle compare ----------------
    logic [3:0] e_uni, e_dez, e_cent;
    logic       e_busy;

    always @(negedge clk) begin
        e_uni  = 4'(nth_from_end(0));
        e_dez  = 4'(nth_from_end(1));
        e_cent = 4'(nth_from_end(2));
        e_busy = (m_phase == M_COLLECT);
        total++;
        if ({busy, rd_valid, digit_err, disp_cent, disp_dez, disp_uni, rd_data} !==
            {e_busy, m_valid, m_err, e_cent, e_dez, e_uni, DW'(m_data)}) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got busy=%b valid=%b err=%b disp=%0d%0d%0d data=%0d want busy=%b valid=%b err=%b disp=%0d%0d%0d data=%0d",
                     $time, busy, rd_valid, digit_err, disp_cent, disp_dez, disp_uni, rd_data,
                     e_busy, m_valid, m_err, e_cent, e_dez, e_uni, m_data);
        end
    end

    // Event monitors used by the hand-computed checks.
    int            valid_cnt = 0;
    int            err_cnt   = 0;
    logic [DW-1:0] last_data = '0;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            valid_cnt++;
            last_data = rd_data;
        end
        if (digit_err === 1'b1) err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic request();
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic press(input bit d, input bit e, input logic [3:0] v);
        sw_in = v;
        tick(3);
        btn_digit = d;
        btn_enter = e;
        tick(N + 6);
        btn_digit = 1'b0;
        btn_enter = 1'b0;
        tick(N + 6);
    endtask

    int v0, e0;
    int nd;
    logic [3:0] rv;

    initial begin
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_disp", {disp_cent, disp_dez, disp_uni}, 0);
        reset = 1'b0;
        tick(2);

        // Reset in the middle of an entry.
        request();
        chk("busy_after_req", busy, 1);
        press(1, 0, 4'd1);
        press(1, 0, 4'd2);
        chk("mid_entry_disp", {disp_cent, disp_dez, disp_uni}, 12'h012);
        v0 = valid_cnt;
        reset = 1'b1;
        tick(2);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_disp", {disp_cent, disp_dez, disp_uni}, 0);
        reset = 1'b0;
        tick(2);
        chk("mid_reset_no_valid", valid_cnt, v0);
        request();
        press(1, 0, 4'd6);
        press(0, 1, 4'd0);
        chk("clean_entry_data", last_data, 6);
        chk("clean_entry_valid_cnt", valid_cnt, v0 + 1);

        // Basic entry 4,2,7.
        request();
        press(1, 0, 4'd4);
        press(1, 0, 4'd2);
        press(1, 0, 4'd7);
        v0 = valid_cnt;
        press(0, 1, 4'd0);
        chk("basic_valid_once", valid_cnt, v0 + 1);
        chk("basic_data", last_data, 427);
        chk("basic_disp", {disp_cent, disp_dez, disp_uni}, 12'h427);
        chk("basic_busy_after", busy, 0);

        // Presses in IDLE are ignored; value holds across idle time.
        press(1, 0, 4'd3);
        press(0, 1, 4'd0);
        tick(100);
        chk("idle_hold_data", rd_data, 427);
        chk("idle_hold_disp", {disp_cent, disp_dez, disp_uni}, 12'h427);
        chk("idle_no_valid", valid_cnt, v0 + 1);

        // Overflow drop and invalid digit.
        request();
        press(1, 0, 4'd1);
        press(1, 0, 4'd2);
        press(1, 0, 4'd3);
        press(1, 0, 4'd5);
        e0 = err_cnt;
        press(1, 0, 4'hC);
        chk("invalid_err_pulse", err_cnt, e0 + 1);
        chk("invalid_disp_kept", {disp_cent, disp_dez, disp_uni}, 12'h235);
        press(0, 1, 4'd0);
        chk("overflow_data", last_data, 235);

        // rd_req during COLLECT does not restart.
        request();
        press(1, 0, 4'd8);
        request();
        chk("req_in_collect_busy", busy, 1);
        press(1, 0, 4'd1);
        press(0, 1, 4'd0);
        chk("req_in_collect_data", last_data, 81);

        // Bounce rejection.
        request();
        sw_in = 4'd5;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            btn_digit = ~btn_digit;
            tick(2);
        end
        btn_digit = 1'b1;
        tick(N + 3);
        chk("bounce_before_latency", disp_uni, 0);
        tick(1);
        chk("bounce_at_latency", disp_uni, 5);
        tick(N + 6);
        btn_digit = 1'b0;
        tick(N + 6);
        chk("bounce_single_shift", {disp_cent, disp_dez, disp_uni}, 12'h005);
        press(0, 1, 4'd0);
        chk("bounce_data", last_data, 5);

        // Simultaneous digit+enter, then empty entry.
        request();
        press(1, 1, 4'd9);
        chk("simul_data", last_data, 9);
        chk("simul_disp", disp_uni, 9);
        request();
        press(0, 1, 4'd0);
        chk("empty_data", last_data, 0);

        // Randomized entries against the model.
        for (int it = 0; it < 25; it++) begin
            request();
            nd = $urandom_range(0, 5);
            for (int j = 0; j < nd; j++) begin
                rv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
                if ($urandom_range(0, 4) == 0) request();
                press(1, 0, rv);
            end
            rv = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) press(1, 1, rv);
            else                           press(0, 1, 4'd0);
            if ($urandom_range(0, 3) == 0) press(1, 0, 4'($urandom_range(0, 9)));
            tick($urandom_range(0, 5));
        end

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
